// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmitter and receiver
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, wraps every CLKS_PER_BIT cycles and flags the last one
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bitEnd
);

  logic [CNT_W-1:0] cnt;

  assign bitEnd = !clr && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || bitEnd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART 8N1 transmitter; defining UART_TX_TWO_STOP_EN selects two stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iValid,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       tx,
  output logic       oBusy,
  output logic       oDone
);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] LAST_STOP = 3'd1;
`else
  localparam logic [2:0] LAST_STOP = 3'd0;
`endif
  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);

  uartState_t                state;
  logic [UART_DATA_BITS-1:0] shift;
  logic [2:0]                bitIdx;
  logic                      bitEnd;

  // Counter is held at zero while idle, so accepting a byte starts a fresh bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) uBaud (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .bitEnd(bitEnd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shift  <= '0;
      bitIdx <= '0;
      tx     <= 1'b1;
      oReady <= 1'b1;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid && oReady) begin
            shift  <= iData;
            tx     <= 1'b0;
            oReady <= 1'b0;
            oBusy  <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            tx     <= shift[0];
            bitIdx <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIdx == LAST_DATA) begin
              tx     <= 1'b1;
              bitIdx <= '0;
              state  <= STOP;
            end else begin
              shift  <= shift >> 1;
              tx     <= shift[1];
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (bitIdx == LAST_STOP) begin
              oReady <= 1'b1;
              oBusy  <= 1'b0;
              oDone  <= 1'b1;
              bitIdx <= '0;
              state  <= IDLE;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx; honours UART_TX_TWO_STOP_EN
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int FRAME = (9 + STOPS) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, tx, oBusy, oDone;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t tab[6];

  logic [7:0] rxQ[$];
  int         rxPos = -1;
  int         rxBit;
  logic [7:0] rxSh;

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .iValid(iValid),
    .iData (iData),
    .oReady(oReady),
    .tx    (tx),
    .oBusy (oBusy),
    .oDone (oDone)
  );

  always #5 clk = ~clk;

  // Mid-bit sampling receiver standing in for the far end of the link.
  always @(negedge clk) begin
    if (!rst) rxPos = -1;
    else if (rxPos < 0) begin
      if (tx === 1'b0) rxPos = 0;
    end else rxPos++;
    if (rxPos >= 0 && (rxPos % CPB) == CPB / 2) begin
      rxBit = rxPos / CPB;
      if (rxBit == 0 && tx !== 1'b0) rxPos = -1;
      else if (rxBit >= 1 && rxBit <= 8) rxSh[rxBit-1] = tx;
      else if (rxBit == 9) begin
        if (tx === 1'b1) rxQ.push_back(rxSh);
        rxPos = -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic expBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else return 1'b1;
  endfunction

  function automatic logic [10:0] modelPattern(input logic [7:0] d);
    logic [10:0] p;
    for (int i = 0; i < 11; i++) p[i] = expBit(d, i);
    return p;
  endfunction

  task automatic waitReady(input string tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (oReady === 1'b1) return;
    end
    chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Called just before the negedge of the first start-bit cycle.
  task automatic watchFrame(input logic [10:0] pat, input logic [7:0] midData,
                            input bit dropValid, input string tag);
    int good[11];
    int busy = 0;
    int notReady = 0;
    int done = 0;
    for (int i = 0; i < 11; i++) good[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (tx === pat[k/CPB]) good[k/CPB]++;
      if (oBusy === 1'b1) busy++;
      if (oReady === 1'b0) notReady++;
      if (oDone === 1'b1) done++;
      if (k == 0 && dropValid) iValid = 1'b0;
      if (k == 40) iData = midData;
    end
    for (int b = 0; b < 9 + STOPS; b++) chk($sformatf("%s_bit%0d", tag, b), good[b], CPB);
    chk({tag, "_busy_cycles"}, busy, FRAME);
    chk({tag, "_notready_cycles"}, notReady, FRAME);
    chk({tag, "_early_done"}, done, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, oDone, 1);
    chk({tag, "_ready_after"}, oReady, 1);
    chk({tag, "_busy_after"}, oBusy, 0);
    chk({tag, "_tx_after"}, tx, 1);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic [10:0] pat, input string tag);
    waitReady(tag);
    iData  = d;
    iValid = 1'b1;
    watchFrame(pat, d, 1'b1, tag);
  endtask

  task automatic abortAt(input logic [7:0] d, input int cyc, input string tag);
    waitReady(tag);
    iData  = d;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    repeat (cyc) @(negedge clk);
    chk({tag, "_tx_before"}, tx, expBit(d, cyc / CPB));
    #2 rst = 1'b0;
    iValid = 1'b1;
    #1;
    chk({tag, "_tx_async"}, tx, 1);
    chk({tag, "_ready_async"}, oReady, 1);
    chk({tag, "_busy_async"}, oBusy, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_tx_in_reset"}, tx, 1);
    iValid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_ready_release"}, oReady, 1);
    chk({tag, "_busy_release"}, oBusy, 0);
  endtask

  initial begin
    int hiTx, hiRdy, hiBusy, hiDone;
    logic [7:0] r;

    tab[0] = '{8'hA5, 10'h34A};
    tab[1] = '{8'h00, 10'h200};
    tab[2] = '{8'hFF, 10'h3FE};
    tab[3] = '{8'h81, 10'h302};
    tab[4] = '{8'h5A, 10'h2B4};
    tab[5] = '{8'h3C, 10'h278};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", oReady, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    rst = 1'b1;

    hiTx = 0; hiRdy = 0; hiBusy = 0; hiDone = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hiTx++;
      if (oReady === 1'b1) hiRdy++;
      if (oBusy === 1'b1) hiBusy++;
      if (oDone === 1'b1) hiDone++;
    end
    chk("idle_tx", hiTx, 50);
    chk("idle_ready", hiRdy, 50);
    chk("idle_busy", hiBusy, 0);
    chk("idle_done", hiDone, 0);

    foreach (tab[i]) sendFrame(tab[i].data, {1'b1, tab[i].frame}, $sformatf("tab%0d", i));

    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom_range(0, 255));
      sendFrame(r, modelPattern(r), $sformatf("rnd%0d_%02h", i, r));
    end

    // Back-to-back with iValid held: second start bit directly after the handshake cycle.
    waitReady("b2b");
    iData  = 8'h00;
    iValid = 1'b1;
    watchFrame(modelPattern(8'h00), 8'hFF, 1'b0, "b2b0");
    watchFrame(modelPattern(8'hFF), 8'hFF, 1'b1, "b2b1");

    rxQ.delete();
    abortAt(8'h3C, 4 * CPB + 5, "abort_d3");
    abortAt(8'h3C, 5, "abort_start");
    chk("abort_rx_empty", rxQ.size(), 0);
    sendFrame(8'h81, modelPattern(8'h81), "post_abort");

    rxQ.delete();
    sendFrame(8'h55, modelPattern(8'h55), "lb55");
    sendFrame(8'hAA, modelPattern(8'hAA), "lbAA");
    sendFrame(8'h01, modelPattern(8'h01), "lb01");
    sendFrame(8'h80, modelPattern(8'h80), "lb80");
    chk("lb_count", rxQ.size(), 4);
    if (rxQ.size() == 4) begin
      chk("lb_byte0", rxQ[0], 8'h55);
      chk("lb_byte1", rxQ[1], 8'hAA);
      chk("lb_byte2", rxQ[2], 8'h01);
      chk("lb_byte3", rxQ[3], 8'h80);
    end

    rxQ.delete();
    sendFrame(8'h5A, modelPattern(8'h5A), "lb5A");
    chk("lb5A_count", rxQ.size(), 1);
    if (rxQ.size() == 1) chk("lb5A_byte", rxQ[0], 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
